// File: rtl/lc4_operand_stage_pkg.sv
// Shared LC4 opcode constants, instruction field positions and operand-usage decode.
// lc4_alu imports the same package so both ends agree on the encoding.
package lc4_operand_stage_pkg;

  localparam int OPC_HI = 19;
  localparam int OPC_LO = 15;
  localparam int RD_HI  = 14;
  localparam int RD_LO  = 12;
  localparam int RS_HI  = 11;
  localparam int RS_LO  = 9;
  localparam int RT_HI  = 7;
  localparam int RT_LO  = 5;

  typedef enum logic [4:0] {
    OP_NOP   = 5'b00000,
    OP_BRN   = 5'b00001,
    OP_BRZ   = 5'b00010,
    OP_BRP   = 5'b00011,
    OP_BRNZP = 5'b00100,
    OP_ADD   = 5'b00101,
    OP_SUB   = 5'b00110,
    OP_MUL   = 5'b00111,
    OP_JSR   = 5'b01000,
    OP_AND   = 5'b01001,
    OP_OR    = 5'b01010,
    OP_CONST = 5'b01011,
    OP_XOR   = 5'b01100,
    OP_SLL   = 5'b01101,
    OP_SRL   = 5'b01110,
    OP_SDRL  = 5'b01111,
    OP_SRA   = 5'b10000,
    OP_NOT   = 5'b10001,
    OP_SDL   = 5'b10010,
    OP_XMP   = 5'b10011,
    OP_TCS   = 5'b10100,
    OP_TCDH  = 5'b10101
  } lc4_opcode_e;

  // NOP and the branch family are the only opcodes without a destination.
  function automatic logic writes_rd(input logic [4:0] op);
    return op > OP_BRNZP;
  endfunction

  function automatic logic uses_rs(input logic [4:0] op);
    return (op > OP_BRNZP) && (op != OP_JSR) && (op != OP_CONST);
  endfunction

  function automatic logic uses_rt(input logic [4:0] op);
    logic r;
    case (op)
      OP_ADD, OP_SUB, OP_SDRL, OP_SDL, OP_XMP: r = 1'b1;
      default:                                 r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lc4_regfile.sv
// NREGS x WORD_SIZE register file: one write port, two combinational read
// ports that forward a same-cycle write, asynchronous active-low clear.
module lc4_regfile #(
  parameter int WORD_SIZE = 256,
  parameter int NREGS     = 8,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic [WORD_SIZE-1:0] wdata,
  input  logic [AW-1:0]        raddr1,
  input  logic [AW-1:0]        raddr2,
  output logic [WORD_SIZE-1:0] rdata1,
  output logic [WORD_SIZE-1:0] rdata2
);

  logic [WORD_SIZE-1:0] regs [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = (we && waddr == raddr1) ? wdata : regs[raddr1];
  assign rdata2 = (we && waddr == raddr2) ? wdata : regs[raddr2];

endmodule

// File: rtl/lc4_operand_stage.sv
// LC4 operand-fetch/issue stage: busy-bit scoreboard against the writeback port,
// one output register feeding lc4_alu, writeback snooping while the output stalls.
module lc4_operand_stage
  import lc4_operand_stage_pkg::*;
#(
  parameter int WORD_SIZE = 256,
  parameter int NREGS     = 8,
  parameter int INSN      = 19,
  parameter int IADDR     = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [INSN:0]        i_insn,
  input  logic [IADDR:0]       i_pc,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [INSN:0]        o_insn,
  output logic [IADDR:0]       o_pc,
  output logic [WORD_SIZE-1:0] o_r1data,
  output logic [WORD_SIZE-1:0] o_r2data,
  output logic                 o_carry,
  input  logic                 i_wb_en,
  input  logic [2:0]           i_wb_rd,
  input  logic [WORD_SIZE-1:0] i_wb_data,
  input  logic                 i_wb_carry_en,
  input  logic                 i_wb_carry
);

  logic [4:0]           in_op, out_op;
  logic [2:0]           in_rd, in_rs, in_rt, out_rs, out_rt;
  logic [NREGS-1:0]     busy, busy_clr, busy_set, busy_eff;
  logic                 blocked, accept, carry_q, carry_eff;
  logic [WORD_SIZE-1:0] rs_data, rt_data;

  assign in_op  = i_insn[OPC_HI:OPC_LO];
  assign in_rd  = i_insn[RD_HI:RD_LO];
  assign in_rs  = i_insn[RS_HI:RS_LO];
  assign in_rt  = i_insn[RT_HI:RT_LO];
  assign out_op = o_insn[OPC_HI:OPC_LO];
  assign out_rs = o_insn[RS_HI:RS_LO];
  assign out_rt = o_insn[RT_HI:RT_LO];

  lc4_regfile #(.WORD_SIZE(WORD_SIZE), .NREGS(NREGS)) u_regfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (i_wb_en),
    .waddr  (i_wb_rd),
    .wdata  (i_wb_data),
    .raddr1 (in_rs),
    .raddr2 (in_rt),
    .rdata1 (rs_data),
    .rdata2 (rt_data)
  );

  // Hazards are judged against the scoreboard after this cycle's writeback clear,
  // so a consumer issues in the same cycle its producer writes back.
  always_comb begin
    busy_clr = '0;
    if (i_wb_en) busy_clr[i_wb_rd] = 1'b1;
  end

  assign busy_eff = busy & ~busy_clr;
  assign blocked  = (uses_rs(in_op) & busy_eff[in_rs]) |
                    (uses_rt(in_op) & busy_eff[in_rt]) |
                    (writes_rd(in_op) & busy_eff[in_rd]);
  assign o_ready  = (!o_valid | i_ready) & !(i_valid & blocked);
  assign accept   = i_valid & o_ready;

  always_comb begin
    busy_set = '0;
    if (accept && writes_rd(in_op)) busy_set[in_rd] = 1'b1;
  end

  assign carry_eff = i_wb_carry_en ? i_wb_carry : carry_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy    <= '0;
      carry_q <= 1'b0;
    end else begin
      busy <= busy_eff | busy_set;
      if (i_wb_carry_en) carry_q <= i_wb_carry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid  <= 1'b0;
      o_insn   <= '0;
      o_pc     <= '0;
      o_r1data <= '0;
      o_r2data <= '0;
      o_carry  <= 1'b0;
    end else if (accept) begin
      o_valid  <= 1'b1;
      o_insn   <= i_insn;
      o_pc     <= i_pc;
      o_r1data <= rs_data;
      o_r2data <= rt_data;
      o_carry  <= carry_eff;
    end else if (o_valid && i_ready) begin
      o_valid <= 1'b0;
    end else if (o_valid) begin
      // Held instruction picks up writebacks only for operands it actually uses.
      if (i_wb_en && uses_rs(out_op) && i_wb_rd == out_rs) o_r1data <= i_wb_data;
      if (i_wb_en && uses_rt(out_op) && i_wb_rd == out_rt) o_r2data <= i_wb_data;
      if (i_wb_carry_en) o_carry <= i_wb_carry;
    end
  end

endmodule

// File: tb/tb_lc4_operand_stage.sv
// Directed bench for lc4_operand_stage: a behavioural model checked every cycle
// plus hand-computed literal expectations for the key scenarios.
module tb_lc4_operand_stage;

  localparam int W = 256;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_valid, o_ready, o_valid, i_ready;
  logic [19:0]   i_insn, o_insn;
  logic [10:0]   i_pc, o_pc;
  logic [W-1:0]  o_r1data, o_r2data, i_wb_data;
  logic          o_carry, i_wb_en, i_wb_carry_en, i_wb_carry;
  logic [2:0]    i_wb_rd;

  int n_cmp = 0;
  int n_bad = 0;

  lc4_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_insn(i_insn), .i_pc(i_pc), .o_valid(o_valid), .i_ready(i_ready),
    .o_insn(o_insn), .o_pc(o_pc), .o_r1data(o_r1data), .o_r2data(o_r2data),
    .o_carry(o_carry), .i_wb_en(i_wb_en), .i_wb_rd(i_wb_rd), .i_wb_data(i_wb_data),
    .i_wb_carry_en(i_wb_carry_en), .i_wb_carry(i_wb_carry)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [19:0] mk(input int op, input int rd, input int rs, input int rt);
    return {op[4:0], rd[2:0], rs[2:0], 1'b0, rt[2:0], 5'b0};
  endfunction

  // ---------------- behavioural model ----------------
  logic [W-1:0] m_regs [8];
  bit   [7:0]   m_busy = '0;
  bit           m_carry = 0, m_valid = 0, m_c = 0;
  logic [19:0]  m_insn = '0;
  logic [10:0]  m_pc = '0;
  logic [W-1:0] m_r1 = '0, m_r2 = '0;

  function automatic bit m_wr(input logic [4:0] op);  return op >= 5; endfunction
  function automatic bit m_urs(input logic [4:0] op); return op >= 5 && op != 8 && op != 11; endfunction
  function automatic bit m_urt(input logic [4:0] op);
    return op == 5 || op == 6 || op == 15 || op == 18 || op == 19;
  endfunction

  function automatic bit m_still_busy(input int r);
    return m_busy[r] && !(i_wb_en && i_wb_rd == r[2:0]);
  endfunction

  function automatic bit m_ready();
    bit blk;
    blk = (m_urs(i_insn[19:15]) && m_still_busy(int'(i_insn[11:9]))) ||
          (m_urt(i_insn[19:15]) && m_still_busy(int'(i_insn[7:5]))) ||
          (m_wr(i_insn[19:15])  && m_still_busy(int'(i_insn[14:12])));
    return (!m_valid || i_ready) && !(i_valid && blk);
  endfunction

  function automatic logic [W-1:0] m_read(input logic [2:0] r);
    return (i_wb_en && i_wb_rd == r) ? i_wb_data : m_regs[r];
  endfunction

  initial for (int i = 0; i < 8; i++) m_regs[i] = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) m_regs[i] = '0;
      m_busy = '0; m_carry = 0; m_valid = 0; m_c = 0;
      m_insn = '0; m_pc = '0; m_r1 = '0; m_r2 = '0;
    end else begin
      bit acc;
      acc = i_valid && m_ready();
      if (acc) begin
        m_valid = 1;
        m_insn  = i_insn;
        m_pc    = i_pc;
        m_r1    = m_read(i_insn[11:9]);
        m_r2    = m_read(i_insn[7:5]);
        m_c     = i_wb_carry_en ? i_wb_carry : m_carry;
      end else if (m_valid && i_ready) begin
        m_valid = 0;
      end else if (m_valid) begin
        if (i_wb_en && m_urs(m_insn[19:15]) && i_wb_rd == m_insn[11:9]) m_r1 = i_wb_data;
        if (i_wb_en && m_urt(m_insn[19:15]) && i_wb_rd == m_insn[7:5])  m_r2 = i_wb_data;
        if (i_wb_carry_en) m_c = i_wb_carry;
      end
      if (i_wb_en) begin
        m_regs[i_wb_rd] = i_wb_data;
        m_busy[i_wb_rd] = 0;
      end
      if (acc && m_wr(i_insn[19:15])) m_busy[i_insn[14:12]] = 1;
      if (i_wb_carry_en) m_carry = i_wb_carry;
    end
  end

  always @(negedge clk) begin
    chk("m_ready", W'(o_ready), W'(m_ready()));
    chk("m_valid", W'(o_valid), W'(m_valid));
    chk("m_insn",  W'(o_insn),  W'(m_insn));
    chk("m_pc",    W'(o_pc),    W'(m_pc));
    chk("m_r1",    o_r1data,    m_r1);
    chk("m_r2",    o_r2data,    m_r2);
    chk("m_carry", W'(o_carry), W'(m_c));
    chk("m_busy",  W'(dut.busy), W'(m_busy));
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input int rd, input logic [W-1:0] d);
    i_wb_en = 1; i_wb_rd = rd[2:0]; i_wb_data = d;
    tick();
    i_wb_en = 0;
  endtask

  initial begin
    rst_n = 0; i_valid = 0; i_ready = 1; i_insn = '0; i_pc = '0;
    i_wb_en = 0; i_wb_rd = '0; i_wb_data = '0; i_wb_carry_en = 0; i_wb_carry = 0;
    tick();
    chk("rst_valid", W'(o_valid), W'(0));
    chk("rst_ready", W'(o_ready), W'(1));
    chk("rst_r1",    o_r1data,    W'(0));
    rst_n = 1;

    wb(1, W'(5));
    wb(2, W'(7));

    // ADD r3 <- r1, r2
    i_insn = mk(5, 3, 1, 2); i_pc = 11'h010; i_valid = 1;
    tick();
    i_valid = 0;
    chk("add_valid", W'(o_valid), W'(1));
    chk("add_r1",    o_r1data,    W'(5));
    chk("add_r2",    o_r2data,    W'(7));
    chk("add_busy3", W'(dut.busy[3]), W'(1));

    // SUB r4 <- r3, r1 stalls on r3 until its writeback, then issues with bypass
    i_insn = mk(6, 4, 3, 1); i_pc = 11'h011; i_valid = 1;
    #1 chk("raw_stall0", W'(o_ready), W'(0));
    tick();
    chk("raw_stall1", W'(o_ready), W'(0));
    i_wb_en = 1; i_wb_rd = 3; i_wb_data = W'(12);
    #1 chk("raw_release", W'(o_ready), W'(1));
    tick();
    i_valid = 0; i_wb_en = 0;
    chk("sub_r1_bypass", o_r1data, W'(12));
    chk("sub_r2",        o_r2data, W'(5));
    chk("sub_insn",      W'(o_insn), W'(mk(6, 4, 3, 1)));
    tick();

    // XMP r5 <- r2, r6 held at the output; r6 writeback snoops into o_r2data
    i_ready = 0;
    i_insn = mk(19, 5, 2, 6); i_pc = 11'h020; i_valid = 1;
    tick();
    i_valid = 0;
    tick();
    chk("xmp_r2_before", o_r2data, W'(0));
    wb(6, W'(8'hFF));
    chk("xmp_r2_snoop", o_r2data, W'(8'hFF));
    chk("xmp_r1_held",  o_r1data, W'(7));
    chk("xmp_insn",     W'(o_insn), W'(mk(19, 5, 2, 6)));
    i_ready = 1;
    tick();

    // CONST r7 does not use rs: a writeback to its rs field must not snoop
    i_ready = 0;
    i_insn = mk(11, 7, 1, 1); i_pc = 11'h030; i_valid = 1;
    tick();
    i_valid = 0;
    wb(1, W'(8'h99));
    chk("const_no_snoop_r1", o_r1data, W'(5));
    chk("const_no_snoop_r2", o_r2data, W'(5));
    i_ready = 1;
    tick();

    // ADD r0 accepted while r0 is written back: set wins, regfile takes wb data
    i_insn = mk(5, 0, 1, 2); i_pc = 11'h040; i_valid = 1;
    i_wb_en = 1; i_wb_rd = 0; i_wb_data = W'(16'h1234);
    tick();
    i_valid = 0; i_wb_en = 0;
    chk("same_rd_busy0", W'(dut.busy[0]), W'(1));
    chk("same_rd_reg0",  dut.u_regfile.regs[0], W'(16'h1234));
    chk("same_rd_r1",    o_r1data, W'(8'h99));

    // TCS with same-cycle carry update
    i_insn = mk(20, 6, 1, 0); i_pc = 11'h050; i_valid = 1;
    i_wb_carry_en = 1; i_wb_carry = 1;
    tick();
    i_valid = 0; i_wb_carry_en = 0; i_wb_carry = 0;
    chk("tcs_carry", W'(o_carry), W'(1));

    // Hazard-free branches at full rate with background writebacks
    for (int i = 0; i < 6; i++) begin
      i_insn = mk(4, 0, 0, 0); i_pc = 11'(11'h100 + i); i_valid = 1;
      i_wb_en = 1; i_wb_rd = 3'(i + 1);
      i_wb_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      #1 chk("tput_ready", W'(o_ready), W'(1));
      tick();
      chk("tput_pc", W'(o_pc), W'(11'h100 + i));
    end
    i_valid = 0; i_wb_en = 0;
    tick();

    // Reset in the middle of a held instruction
    i_ready = 0;
    i_insn = mk(5, 3, 1, 2); i_pc = 11'h060; i_valid = 1;
    tick();
    i_valid = 0;
    #2 rst_n = 0;
    #1;
    chk("arst_valid", W'(o_valid), W'(0));
    chk("arst_busy",  W'(dut.busy), W'(0));
    chk("arst_insn",  W'(o_insn), W'(0));
    chk("arst_r1",    o_r1data, W'(0));
    chk("arst_reg1",  dut.u_regfile.regs[1], W'(0));
    #2 rst_n = 1;
    i_ready = 1;
    i_insn = mk(5, 3, 1, 2); i_pc = 11'h070; i_valid = 1;
    tick();
    i_valid = 0;
    chk("post_rst_valid", W'(o_valid), W'(1));
    chk("post_rst_pc",    W'(o_pc), W'(11'h070));
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
